// File: rtl/conf_regbank_pkg.sv
// Shared types for the uncached configuration register bank: FSM states and response record.
// The response data field is CONF_RSP_W wide; REG_W of the bank must not exceed it.
package conf_regbank_pkg;

  localparam int unsigned CONF_RSP_W = 64;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } conf_state_e;

  typedef struct packed {
    logic [CONF_RSP_W-1:0] rdata;
    logic                  err;
  } conf_rsp_t;

endpackage

// File: rtl/conf_regbank_decode.sv
// Combinational address decode: 8-byte register index, RW/RO hit and decode error.
module conf_regbank_decode
  import conf_regbank_pkg::*;
#(
  parameter int unsigned RW_NUM = 4,
  parameter int unsigned RO_NUM = 4,
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned IDX_W  = ADDR_W - 3
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic              write,
  output logic [IDX_W-1:0]  idx,
  output logic              rw_hit,
  output logic              ro_hit,
  output logic              err
);

  localparam logic [IDX_W-1:0] RW_LIM = IDX_W'(RW_NUM);
  localparam logic [IDX_W-1:0] RO_LIM = IDX_W'(RW_NUM + RO_NUM);

  assign idx    = addr[ADDR_W-1:3];
  assign rw_hit = (idx < RW_LIM);
  assign ro_hit = !rw_hit && (idx < RO_LIM);
  // Misalignment, unmapped index and stores into status space all fail.
  assign err    = (|addr[2:0]) || !(rw_hit || ro_hit) || (write && ro_hit);

endmodule

// File: rtl/uncached_config_regbank.sv
// Single-outstanding uncached config/status register bank with byte-enabled stores.
// Load readback is enabled by defining COHORT_CONF_READBACK_EN; otherwise loads return an error.
module uncached_config_regbank
  import conf_regbank_pkg::*;
#(
  parameter int unsigned RW_NUM = 4,
  parameter int unsigned RO_NUM = 4,
  parameter int unsigned REG_W  = 64,
  parameter int unsigned ADDR_W = 12
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           req_valid_i,
  output logic                           req_ready_o,
  input  logic                           req_write_i,
  input  logic [ADDR_W-1:0]              req_addr_i,
  input  logic [REG_W-1:0]               req_wdata_i,
  input  logic [REG_W/8-1:0]             req_be_i,
  output logic                           rsp_valid_o,
  input  logic                           rsp_ready_i,
  output logic [REG_W-1:0]               rsp_rdata_o,
  output logic                           rsp_err_o,
  input  logic [RO_NUM-1:0][REG_W-1:0]   ro_reg_i,
  output logic [RW_NUM-1:0][REG_W-1:0]   rw_reg_o,
  output logic [RW_NUM-1:0]              wr_pulse_o
);

  localparam int unsigned IDX_W = ADDR_W - 3;
  localparam int unsigned BE_W  = REG_W / 8;

  conf_state_e                 state_reg, state_next;
  conf_rsp_t                   rsp_reg, rsp_next;
  logic [RW_NUM-1:0]           wr_pulse_reg;
  logic [RW_NUM-1:0]           wr_sel;
  logic [RW_NUM-1:0][REG_W-1:0] rw_regs;
  logic [IDX_W-1:0]            idx;
  logic                        rw_hit, ro_hit, dec_err;
  logic                        accept;

  conf_regbank_decode #(
    .RW_NUM (RW_NUM),
    .RO_NUM (RO_NUM),
    .ADDR_W (ADDR_W),
    .IDX_W  (IDX_W)
  ) u_decode (
    .addr   (req_addr_i),
    .write  (req_write_i),
    .idx    (idx),
    .rw_hit (rw_hit),
    .ro_hit (ro_hit),
    .err    (dec_err)
  );

  assign accept = (state_reg == ST_IDLE) && req_valid_i;

  always_comb begin
    state_next  = state_reg;
    req_ready_o = 1'b0;
    rsp_valid_o = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) state_next = ST_RESP;
      end
      ST_RESP: begin
        rsp_valid_o = 1'b1;
        if (rsp_ready_i) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

`ifdef COHORT_CONF_READBACK_EN
  logic [REG_W-1:0] load_data;

  always_comb begin
    load_data = '0;
    for (int i = 0; i < RW_NUM; i++)
      if (rw_hit && idx == IDX_W'(i)) load_data = rw_regs[i];
    for (int j = 0; j < RO_NUM; j++)
      if (ro_hit && idx == IDX_W'(RW_NUM + j)) load_data = ro_reg_i[j];
  end

  assign rsp_next.err   = dec_err;
  assign rsp_next.rdata = (req_write_i || dec_err) ? '0 : CONF_RSP_W'(load_data);
`else
  assign rsp_next.err   = dec_err || !req_write_i;
  assign rsp_next.rdata = '0;
`endif

  // Response is captured at acceptance and wiped on completion so idle data reads zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      rsp_reg      <= '0;
      wr_pulse_reg <= '0;
    end else begin
      state_reg    <= state_next;
      wr_pulse_reg <= wr_sel;
      if (accept)
        rsp_reg <= rsp_next;
      else if (state_reg == ST_RESP && rsp_ready_i)
        rsp_reg <= '0;
    end
  end

  for (genvar gi = 0; gi < RW_NUM; gi++) begin : g_rw
    logic [REG_W-1:0] val_reg;

    assign wr_sel[gi] = accept && req_write_i && !dec_err && rw_hit && (idx == IDX_W'(gi));

    always_ff @(posedge clk) begin
      if (rst) begin
        val_reg <= '0;
      end else if (wr_sel[gi]) begin
        for (int b = 0; b < BE_W; b++)
          if (req_be_i[b]) val_reg[b*8 +: 8] <= req_wdata_i[b*8 +: 8];
      end
    end

    assign rw_regs[gi] = val_reg;
  end

  assign rsp_rdata_o = rsp_reg.rdata[REG_W-1:0];
  assign rsp_err_o   = rsp_reg.err;
  assign wr_pulse_o  = wr_pulse_reg;
  assign rw_reg_o    = rw_regs;

endmodule

// File: tb/tb_uncached_config_regbank.sv
// Directed scoreboard bench for uncached_config_regbank; expectations follow COHORT_CONF_READBACK_EN.
module tb_uncached_config_regbank;

`ifdef COHORT_CONF_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  typedef struct {
    logic [63:0] rdata;
    logic        err;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic             req_write = 1'b0;
  logic [11:0]      req_addr = '0;
  logic [63:0]      req_wdata = '0;
  logic [7:0]       req_be = '0;
  logic             rsp_valid;
  logic             rsp_ready = 1'b0;
  logic [63:0]      rsp_rdata;
  logic             rsp_err;
  logic [3:0][63:0] ro_reg = '0;
  logic [3:0][63:0] rw_reg;
  logic [3:0]       wr_pulse;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  uncached_config_regbank dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_write_i (req_write),
    .req_addr_i  (req_addr),
    .req_wdata_i (req_wdata),
    .req_be_i    (req_be),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_rdata_o (rsp_rdata),
    .rsp_err_o   (rsp_err),
    .ro_reg_i    (ro_reg),
    .rw_reg_o    (rw_reg),
    .wr_pulse_o  (wr_pulse)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one request, push its expected response, and check it in the first RESP cycle.
  task automatic send(input logic wr, input logic [11:0] addr, input logic [63:0] wdata,
                      input logic [7:0] be, input logic [63:0] er, input logic ee);
    exp_t e;
    @(negedge clk);
    chk("req_ready_idle", req_ready, 1'b1);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wdata;
    req_be    = be;
    sb.push_back('{rdata: er, err: ee});
    @(negedge clk);
    req_valid = 1'b0;
    e = sb.pop_front();
    chk("rsp_valid", rsp_valid, 1'b1);
    chk("rsp_rdata", rsp_rdata, e.rdata);
    chk("rsp_err", rsp_err, e.err);
    $display("txn wr=%0d addr=%h wdata=%h be=%h -> rdata=%h err=%0d", wr, addr, wdata, be, rsp_rdata, rsp_err);
  endtask

  task automatic finish_rsp();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("rsp_done_valid", rsp_valid, 1'b0);
    chk("rsp_done_rdata", rsp_rdata, 64'h0);
    chk("rsp_done_err", rsp_err, 1'b0);
  endtask

  initial begin
    logic [3:0][63:0] snap;
    exp_t held;

    ro_reg[0] = 64'h0101_0101_0101_0101;
    ro_reg[1] = 64'hA5A5_0000_5A5A_FFFF;
    ro_reg[2] = 64'h0000_0000_0000_1234;
    ro_reg[3] = 64'hFFFF_0000_FFFF_0000;

    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("reset_req_ready", req_ready, 1'b1);
    chk("reset_rsp_valid", rsp_valid, 1'b0);
    chk("reset_rsp_err", rsp_err, 1'b0);
    chk("reset_rsp_rdata", rsp_rdata, 64'h0);
    chk("reset_wr_pulse", wr_pulse, 4'b0000);
    for (int i = 0; i < 4; i++) chk("reset_rw", rw_reg[i], 64'h0);

    // Full store to index 1.
    send(1'b1, 12'h008, 64'hDEADBEEF_CAFEF00D, 8'hFF, 64'h0, 1'b0);
    chk("st1_pulse", wr_pulse, 4'b0010);
    chk("st1_rw1", rw_reg[1], 64'hDEADBEEF_CAFEF00D);
    finish_rsp();
    chk("st1_pulse_gone", wr_pulse, 4'b0000);

    // Lower-half byte enables on index 0.
    send(1'b1, 12'h000, 64'hFFFFFFFF_FFFFFFFF, 8'h0F, 64'h0, 1'b0);
    chk("st0_pulse", wr_pulse, 4'b0001);
    chk("st0_rw0", rw_reg[0], 64'h00000000_FFFFFFFF);
    finish_rsp();

    // No bytes enabled: strobe still fires, data unchanged.
    send(1'b1, 12'h010, 64'h1111_2222_3333_4444, 8'h00, 64'h0, 1'b0);
    chk("st_be0_pulse", wr_pulse, 4'b0100);
    chk("st_be0_rw2", rw_reg[2], 64'h0);
    finish_rsp();

    // Loads of an RW and an RO register.
    send(1'b0, 12'h008, 64'h0, 8'h00, RB ? 64'hDEADBEEF_CAFEF00D : 64'h0, !RB);
    chk("ld_rw_pulse", wr_pulse, 4'b0000);
    finish_rsp();
    send(1'b0, 12'h030, 64'h0, 8'h00, RB ? 64'h1234 : 64'h0, !RB);
    finish_rsp();

    // Out-of-range misaligned load, then store into status space.
    send(1'b0, 12'h044, 64'h0, 8'h00, 64'h0, 1'b1);
    finish_rsp();
    snap = rw_reg;
    send(1'b1, 12'h020, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 64'h0, 1'b1);
    chk("st_ro_pulse", wr_pulse, 4'b0000);
    finish_rsp();
    for (int i = 0; i < 4; i++) chk("st_ro_rw_unchanged", rw_reg[i], snap[i]);

    // Misaligned store to an otherwise valid RW index.
    send(1'b1, 12'h00C, 64'h0, 8'hFF, 64'h0, 1'b1);
    chk("st_misal_pulse", wr_pulse, 4'b0000);
    finish_rsp();
    chk("st_misal_rw1", rw_reg[1], 64'hDEADBEEF_CAFEF00D);

    // Backpressure with a competing request presented during RESP.
    send(1'b0, 12'h000, 64'h0, 8'h00, RB ? 64'h00000000_FFFFFFFF : 64'h0, !RB);
    held.rdata = RB ? 64'h00000000_FFFFFFFF : 64'h0;
    held.err   = !RB;
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 12'h018;
    req_wdata = 64'hABCD_ABCD_ABCD_ABCD;
    req_be    = 8'hFF;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("bp_rsp_valid", rsp_valid, 1'b1);
      chk("bp_rsp_rdata", rsp_rdata, held.rdata);
      chk("bp_rsp_err", rsp_err, held.err);
      chk("bp_req_ready", req_ready, 1'b0);
      chk("bp_wr_pulse", wr_pulse, 4'b0000);
    end
    req_valid = 1'b0;
    finish_rsp();
    chk("bp_rw3_untouched", rw_reg[3], 64'h0);
    chk("bp_no_pulse", wr_pulse, 4'b0000);

    // Reset while a store response is pending.
    send(1'b1, 12'h018, 64'h5555_6666_7777_8888, 8'hFF, 64'h0, 1'b0);
    chk("rst_mid_pulse", wr_pulse, 4'b1000);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_valid", rsp_valid, 1'b0);
    chk("rst_mid_ready", req_ready, 1'b1);
    chk("rst_mid_err", rsp_err, 1'b0);
    chk("rst_mid_pulse_clr", wr_pulse, 4'b0000);
    for (int i = 0; i < 4; i++) chk("rst_mid_rw", rw_reg[i], 64'h0);
    @(negedge clk);
    chk("rst_mid_no_pulse", wr_pulse, 4'b0000);
    chk("rst_mid_still_idle", rsp_valid, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
